dot_product_sequencer: RTL and testbench

DOT_PRODUCT_SEQUENCER -- requirements
Module: dot_product_sequencer

---
 rtl/quant_pkg.sv | 24 ++
 rtl/seq_elem_buf.sv | 52 +++++
 rtl/dot_product_sequencer.sv | 140 ++++++++++++++
 tb/tb_dot_product_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quant_pkg.sv
// ============================================================================
// Module      : quant_pkg
// Description : Shared types and constants for the dot-product sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package quant_pkg;

    localparam int c_data_w          = 32;
    localparam int c_wgt_w           = 8;
    localparam int c_def_vec_len     = 16;
    localparam int c_def_timeout_cyc = 255;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } seq_state_t;

endpackage : quant_pkg

`default_nettype wire

// File: rtl/seq_elem_buf.sv
// ============================================================================
// Module      : seq_elem_buf
// Description : Register buffer of {activation, weight} pairs; one write
//               port, combinational read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_elem_buf
    import quant_pkg::*;
#(
    parameter int VEC_LEN = c_def_vec_len
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         wr_en_i,
    input  logic [$clog2(VEC_LEN)-1:0]   wr_addr_i,
    input  logic signed [c_data_w-1:0]   wr_x_i,
    input  logic signed [c_wgt_w-1:0]    wr_w_i,
    input  logic [$clog2(VEC_LEN)-1:0]   rd_addr_i,
    output logic signed [c_data_w-1:0]   rd_x_o,
    output logic signed [c_wgt_w-1:0]    rd_w_o
);

    localparam int              c_aw    = $clog2(VEC_LEN);
    localparam logic [c_aw:0]   c_depth = (c_aw + 1)'(VEC_LEN);

    logic signed [c_data_w-1:0] r_x [VEC_LEN];
    logic signed [c_wgt_w-1:0]  r_w [VEC_LEN];
    logic                       w_in_range;

    // Non-power-of-two depths leave unused address codes that must be dropped.
    assign w_in_range = ({1'b0, wr_addr_i} < c_depth);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < VEC_LEN; i++) begin
                r_x[i] <= '0;
                r_w[i] <= '0;
            end
        end else if (wr_en_i && w_in_range) begin
            r_x[wr_addr_i] <= wr_x_i;
            r_w[wr_addr_i] <= wr_w_i;
        end
    end

    assign rd_x_o = r_x[rd_addr_i];
    assign rd_w_o = r_w[rd_addr_i];

endmodule : seq_elem_buf

`default_nettype wire

// File: rtl/dot_product_sequencer.sv
// ============================================================================
// Module      : dot_product_sequencer
// Description : Streams a buffered vector into a quantize/MAC pipeline and
//               captures its result. Option macro: RELU_OUTPUT_EN clamps
//               negative captured results to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dot_product_sequencer
    import quant_pkg::*;
#(
    parameter int VEC_LEN     = c_def_vec_len,
    parameter int TIMEOUT_CYC = c_def_timeout_cyc
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         wr_en_i,
    input  logic [$clog2(VEC_LEN)-1:0]   wr_addr_i,
    input  logic signed [c_data_w-1:0]   wr_x_i,
    input  logic signed [c_wgt_w-1:0]    wr_w_i,
    input  logic                         start_i,
    output logic                         pipe_start_o,
    output logic signed [c_data_w-1:0]   vector_x_o,
    output logic signed [c_wgt_w-1:0]    quant_w_o,
    input  logic                         pipe_done_i,
    input  logic signed [c_data_w-1:0]   pipe_dout_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic signed [c_data_w-1:0]   result_o,
    output logic                         err_o
);

    localparam int              c_aw        = $clog2(VEC_LEN);
    localparam int              c_tw        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_aw-1:0] c_last_elem = c_aw'(VEC_LEN - 1);
    localparam logic [c_tw-1:0] c_last_wait = c_tw'(TIMEOUT_CYC - 1);

    seq_state_t                 r_state;
    seq_state_t                 w_state_nxt;
    logic [c_aw-1:0]            r_elem_cnt;
    logic [c_tw-1:0]            r_wait_cnt;
    logic signed [c_data_w-1:0] r_result;
    logic                       r_err;
    logic signed [c_data_w-1:0] w_rd_x;
    logic signed [c_wgt_w-1:0]  w_rd_w;
    logic signed [c_data_w-1:0] w_capture;
    logic                       w_idle;
    logic                       w_stream;
    logic                       w_buf_wr;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_stream = (r_state == ST_STREAM);
    assign w_buf_wr = wr_en_i & w_idle;

    seq_elem_buf #(
        .VEC_LEN (VEC_LEN)
    ) u_elem_buf (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .wr_en_i   (w_buf_wr),
        .wr_addr_i (wr_addr_i),
        .wr_x_i    (wr_x_i),
        .wr_w_i    (wr_w_i),
        .rd_addr_i (r_elem_cnt),
        .rd_x_o    (w_rd_x),
        .rd_w_o    (w_rd_w)
    );

    always_comb begin
        w_capture = pipe_dout_i;
`ifdef RELU_OUTPUT_EN
        if (pipe_dout_i < 0) begin
            w_capture = '0;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (start_i) w_state_nxt = ST_STREAM;
            ST_STREAM: if (r_elem_cnt == c_last_elem) w_state_nxt = ST_WAIT;
            ST_WAIT:   if (pipe_done_i || (r_wait_cnt == c_last_wait)) w_state_nxt = ST_DONE;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // A pipeline response on the final WAIT cycle wins over the timeout.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_elem_cnt <= '0;
            r_wait_cnt <= '0;
            r_result   <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_elem_cnt <= '0;
                        r_wait_cnt <= '0;
                        r_err      <= 1'b0;
                    end
                end
                ST_STREAM: begin
                    r_elem_cnt <= (r_elem_cnt == c_last_elem) ? '0 : r_elem_cnt + 1'b1;
                end
                ST_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                    if (pipe_done_i) begin
                        r_result <= w_capture;
                    end else if (r_wait_cnt == c_last_wait) begin
                        r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pipe_start_o = w_stream;
    assign vector_x_o   = w_stream ? w_rd_x : '0;
    assign quant_w_o    = w_stream ? w_rd_w : '0;
    assign busy_o       = ~w_idle;
    assign done_o       = (r_state == ST_DONE);
    assign result_o     = r_result;
    assign err_o        = r_err;

endmodule : dot_product_sequencer

`default_nettype wire

// File: tb/tb_dot_product_sequencer.sv
// ============================================================================
// Module      : tb_dot_product_sequencer
// Description : Self-checking bench for dot_product_sequencer (table-driven
//               operations, randomized data, behavioural buffer model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dot_product_sequencer;

    localparam int VL = 16;
    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic        wr_en_i;
    logic [3:0]  wr_addr_i;
    logic [31:0] wr_x_i;
    logic [7:0]  wr_w_i;
    logic        start_i;
    logic        pipe_start_o;
    logic [31:0] vector_x_o;
    logic [7:0]  quant_w_o;
    logic        pipe_done_i;
    logic [31:0] pipe_dout_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic        err_o;

    always #5 clk = ~clk;

    dot_product_sequencer #(
        .VEC_LEN     (VL),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_i        (clk),
        .rstn_i       (rstn_i),
        .wr_en_i      (wr_en_i),
        .wr_addr_i    (wr_addr_i),
        .wr_x_i       (wr_x_i),
        .wr_w_i       (wr_w_i),
        .start_i      (start_i),
        .pipe_start_o (pipe_start_o),
        .vector_x_o   (vector_x_o),
        .quant_w_o    (quant_w_o),
        .pipe_done_i  (pipe_done_i),
        .pipe_dout_i  (pipe_dout_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .result_o     (result_o),
        .err_o        (err_o)
    );

    int n_err = 0;
    int n_chk = 0;

    // Behavioural model: buffer contents and last captured result.
    logic [31:0] m_x [VL];
    logic [7:0]  m_w [VL];
    logic [31:0] m_result;

    typedef struct {
        int          pattern;     // 0: x=i+1,w=2  1: random  2: keep buffer
        bit          respond;
        logic [31:0] dout;
        bit          intrude;
        logic [31:0] exp_result;
        bit          exp_err;
    } op_t;

    op_t tbl [6];

    function automatic logic [31:0] relu_ref(input logic [31:0] v);
`ifdef RELU_OUTPUT_EN
        return ($signed(v) < 0) ? 32'd0 : v;
`else
        return v;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)",
                     name, $signed(act), act, $signed(exp), exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_elem(input int a, input logic [31:0] x, input logic [7:0] w);
        wr_en_i   = 1'b1;
        wr_addr_i = 4'(a);
        wr_x_i    = x;
        wr_w_i    = w;
        tick();
        wr_en_i   = 1'b0;
        m_x[a]    = x;
        m_w[a]    = w;
    endtask

    task automatic run_op(input int pattern, input bit respond, input logic [31:0] dout,
                          input bit intrude, input logic [31:0] exp_result, input bit exp_err);
        int          a;
        int          n;
        logic [31:0] nx;
        logic [7:0]  nw;
        a = 0;
        nx = '0;
        nw = '0;
        if (pattern == 0) begin
            for (int i = 0; i < VL; i++) write_elem(i, 32'(i + 1), 8'd2);
        end else if (pattern == 1) begin
            for (int i = 0; i < VL; i++) write_elem(i, $urandom, 8'($urandom));
        end
        start_i = 1'b1;
        if (pattern == 1) begin
            // same-cycle write must be visible to the stream it starts
            a         = $urandom_range(0, VL - 1);
            nx        = $urandom;
            nw        = 8'($urandom);
            wr_en_i   = 1'b1;
            wr_addr_i = 4'(a);
            wr_x_i    = nx;
            wr_w_i    = nw;
        end
        tick();
        if (pattern == 1) begin
            m_x[a] = nx;
            m_w[a] = nw;
        end
        start_i = 1'b0;
        wr_en_i = 1'b0;
        check("busy_after_start", busy_o, 1);
        check("err_cleared_on_start", err_o, 0);
        for (int i = 0; i < VL; i++) begin
            check("pipe_start_high", pipe_start_o, 1);
            check("stream_x", vector_x_o, m_x[i]);
            check("stream_w", quant_w_o, m_w[i]);
            if (intrude && i == 3) begin
                start_i   = 1'b1;
                wr_en_i   = 1'b1;
                wr_addr_i = 4'd0;
                wr_x_i    = 32'd99;
                wr_w_i    = 8'h55;
            end
            tick();
            start_i = 1'b0;
            wr_en_i = 1'b0;
        end
        check("pipe_start_low_after_stream", pipe_start_o, 0);
        check("vector_x_zero_in_wait", vector_x_o, 0);
        check("quant_w_zero_in_wait", quant_w_o, 0);
        check("busy_in_wait", busy_o, 1);
        if (respond) begin
            repeat ($urandom_range(0, 4)) begin
                pipe_dout_i = $urandom;
                tick();
            end
            pipe_done_i = 1'b1;
            pipe_dout_i = dout;
            tick();
            pipe_done_i = 1'b0;
        end else begin
            pipe_dout_i = dout;
            n = 0;
            while (!done_o && n < TO + 50) begin
                tick();
                n++;
            end
            check("timeout_wait_cycles", n, TO);
        end
        check("done_pulse", done_o, 1);
        check("result_capture", result_o, exp_result);
        check("err_flag", err_o, 32'(exp_err));
        tick();
        check("done_one_cycle", done_o, 0);
        check("idle_after_done", busy_o, 0);
        if (intrude) begin
            n = 0;
            repeat (20) begin
                tick();
                if (busy_o || done_o) n++;
            end
            check("no_queued_start", n, 0);
        end
        m_result = exp_result;
    endtask

    initial begin
        int          n;
        bit          rsp;
        logic [31:0] d;

        tbl[0] = '{0, 1'b1, 32'd272,        1'b0, 32'd272,                 1'b0};
        tbl[1] = '{1, 1'b1, -32'sd5,        1'b0, relu_ref(-32'sd5),       1'b0};
        tbl[2] = '{1, 1'b0, 32'd1234,       1'b0, relu_ref(-32'sd5),       1'b1};
        tbl[3] = '{1, 1'b1, 32'd7,          1'b1, 32'd7,                   1'b0};
        tbl[4] = '{2, 1'b1, 32'h7fff_ffff,  1'b0, 32'h7fff_ffff,           1'b0};
        tbl[5] = '{1, 1'b1, 32'h8000_0000,  1'b0, relu_ref(32'h8000_0000), 1'b0};

        rstn_i      = 1'b0;
        wr_en_i     = 1'b0;
        wr_addr_i   = '0;
        wr_x_i      = '0;
        wr_w_i      = '0;
        start_i     = 1'b0;
        pipe_done_i = 1'b0;
        pipe_dout_i = '0;
        for (int i = 0; i < VL; i++) begin
            m_x[i] = '0;
            m_w[i] = '0;
        end
        m_result = '0;
        repeat (2) tick();
        check("reset_busy", busy_o, 0);
        check("reset_done", done_o, 0);
        check("reset_pipe_start", pipe_start_o, 0);
        check("reset_vector_x", vector_x_o, 0);
        check("reset_quant_w", quant_w_o, 0);
        check("reset_result", result_o, 0);
        check("reset_err", err_o, 0);
        rstn_i = 1'b1;
        tick();

        for (int t = 0; t < 6; t++) begin
            run_op(tbl[t].pattern, tbl[t].respond, tbl[t].dout, tbl[t].intrude,
                   tbl[t].exp_result, tbl[t].exp_err);
        end

        for (int k = 0; k < 6; k++) begin
            rsp = ($urandom_range(0, 3) != 0);
            d   = $urandom;
            run_op(1, rsp, d, 1'b0, rsp ? relu_ref(d) : m_result, !rsp);
        end

        // reset in the middle of a stream
        for (int i = 0; i < VL; i++) write_elem(i, $urandom, 8'($urandom));
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (5) tick();
        rstn_i = 1'b0;
        #1;
        check("midrst_pipe_start", pipe_start_o, 0);
        check("midrst_vector_x", vector_x_o, 0);
        check("midrst_quant_w", quant_w_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_done", done_o, 0);
        check("midrst_result", result_o, 0);
        check("midrst_err", err_o, 0);
        tick();
        rstn_i = 1'b1;
        for (int i = 0; i < VL; i++) begin
            m_x[i] = '0;
            m_w[i] = '0;
        end
        m_result = '0;
        n = 0;
        repeat (10) begin
            tick();
            if (done_o || busy_o) n++;
        end
        check("midrst_no_done", n, 0);
        run_op(2, 1'b1, 32'd42, 1'b0, 32'd42, 1'b0);

        // pipeline done outside WAIT is ignored
        pipe_done_i = 1'b1;
        pipe_dout_i = 32'd555;
        tick();
        pipe_done_i = 1'b0;
        check("idle_done_ignored_result", result_o, m_result);
        check("idle_done_ignored_busy", busy_o, 0);
        check("idle_done_ignored_done", done_o, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_dot_product_sequencer

`default_nettype wire
